// File: rtl/f2_pkg.sv
// Shared definitions for the f2 command sequencer: GPU instruction codes,
// FSM state encoding and the request priority helpers.
package f2_pkg;

  typedef enum logic [2:0] {
    CMD_NONE     = 3'd0,
    CMD_PREV     = 3'd1,
    CMD_NEXT     = 3'd2,
    CMD_ROTATE   = 3'd3,
    CMD_NEGATIVE = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    WAIT    = 2'd3
  } state_e;

  // Pending bit order: [0]=prev, [1]=next, [2]=rotate, [3]=negative.
  function automatic cmd_e pick_cmd(input logic [3:0] pend);
    if (pend[0])      return CMD_PREV;
    else if (pend[1]) return CMD_NEXT;
    else if (pend[2]) return CMD_ROTATE;
    else if (pend[3]) return CMD_NEGATIVE;
    else              return CMD_NONE;
  endfunction

  function automatic logic [3:0] cmd_mask(input cmd_e c);
    case (c)
      CMD_PREV:     return 4'b0001;
      CMD_NEXT:     return 4'b0010;
      CMD_ROTATE:   return 4'b0100;
      CMD_NEGATIVE: return 4'b1000;
      default:      return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/f2_btn_debounce.sv
// Two-flop synchronizer, counting debouncer and one-cycle rising-edge pulse
// for one raw front-panel button.
module f2_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_q <= level;
      // Any agreement restarts the stability count.
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/f2_cmd_sequencer.sv
// Debounces panel buttons, arbitrates requests and drives shaped GPU instruction
// pulses with post-navigation lockout. Optional slideshow via F2_SLIDESHOW_EN.
import f2_pkg::*;

module f2_cmd_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 4,
  parameter int ANIME_CYCLES    = 134217728,
  parameter int SLIDE_CYCLES    = 250000000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       btn_prev,
  input  logic       btn_next,
  input  logic       btn_rotate,
  input  logic       btn_negative,
  input  logic       btn_slide,
  output logic [2:0] instruction,
  output logic       busy,
  output logic       slideshow_on
);

  localparam int CNT_MAX = (HOLD_CYCLES > ANIME_CYCLES) ? HOLD_CYCLES : ANIME_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ANIME_LAST = CW'(ANIME_CYCLES - 1);
  localparam logic [CW-1:0] CNT_TOP    = CW'(CNT_MAX - 1);

  state_e        state;
  state_e        next_state;
  cmd_e          cmd_q;
  cmd_e          grant_cmd;
  logic [CW-1:0] cnt;
  logic [3:0]    raw;
  logic [3:0]    rise;
  logic [3:0]    pending;
  logic [3:0]    grant_mask;
  logic          grant_any;
  logic          slide_fire;

  assign raw = {btn_negative, btn_rotate, btn_next, btn_prev};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    f2_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (sysclk),
      .rst  (rst),
      .raw  (raw[i]),
      .rise (rise[i])
    );
  end

  assign grant_cmd  = pick_cmd(pending);
  assign grant_any  = (state == IDLE) && (pending != 4'b0000);
  assign grant_mask = grant_any ? cmd_mask(grant_cmd) : 4'b0000;

  // A fresh press on the bit being granted survives as a new request.
  always_ff @(posedge sysclk) begin
    if (rst) pending <= 4'b0000;
    else     pending <= (pending & ~grant_mask) | rise | {2'b00, slide_fire, 1'b0};
  end

`ifdef F2_SLIDESHOW_EN
  localparam int SW = $clog2(SLIDE_CYCLES + 1);
  localparam logic [SW-1:0] SLIDE_LAST = SW'(SLIDE_CYCLES - 1);

  logic          slide_rise;
  logic          slide_on;
  logic          slide_armed;
  logic [SW-1:0] slide_tmr;

  f2_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_slide (
    .clk  (sysclk),
    .rst  (rst),
    .raw  (btn_slide),
    .rise (slide_rise)
  );

  assign slide_armed = slide_on && (state == IDLE) && (pending == 4'b0000);
  assign slide_fire  = slide_armed && !slide_rise && (slide_tmr == SLIDE_LAST);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      slide_on  <= 1'b0;
      slide_tmr <= '0;
    end else begin
      if (slide_rise) slide_on <= ~slide_on;
      if (slide_rise || grant_any || slide_fire) slide_tmr <= '0;
      else if (slide_armed)                      slide_tmr <= slide_tmr + 1'b1;
    end
  end

  assign slideshow_on = slide_on;
`else
  logic unused_slide;
  assign unused_slide = btn_slide;
  assign slide_fire   = 1'b0;
  assign slideshow_on = 1'b0;
`endif

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
    end
  end

  // One counter serves every state; it restarts on each state entry.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      cnt   <= '0;
      cmd_q <= CMD_NONE;
    end else begin
      if (grant_any) cmd_q <= grant_cmd;
      if (next_state != state) cnt <= '0;
      else if (cnt != CNT_TOP) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_any) next_state = ISSUE;
      ISSUE:   if (cnt == HOLD_LAST) next_state = RELEASE;
      RELEASE: next_state = (cmd_q == CMD_PREV || cmd_q == CMD_NEXT) ? WAIT : IDLE;
      WAIT:    if (cnt == ANIME_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    instruction = CMD_NONE;
    if (state == ISSUE) instruction = cmd_q;
  end

endmodule

// File: tb/tb_f2_cmd_sequencer.sv
// Directed bench for f2_cmd_sequencer with DEBOUNCE=4, HOLD=2, ANIME=16, SLIDE=32;
// edge numbers in each scenario are relative to the edge after which stimulus starts.
module tb_f2_cmd_sequencer;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_prev = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_rotate = 1'b0;
  logic       btn_negative = 1'b0;
  logic       btn_slide = 1'b0;
  logic [2:0] instruction;
  logic       busy;
  logic       slideshow_on;

  int checks = 0;
  int errors = 0;

  always #5 sysclk = ~sysclk;

  f2_cmd_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (2),
    .ANIME_CYCLES    (16),
    .SLIDE_CYCLES    (32)
  ) dut (
    .sysclk       (sysclk),
    .rst          (rst),
    .btn_prev     (btn_prev),
    .btn_next     (btn_next),
    .btn_rotate   (btn_rotate),
    .btn_negative (btn_negative),
    .btn_slide    (btn_slide),
    .instruction  (instruction),
    .busy         (busy),
    .slideshow_on (slideshow_on)
  );

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step(); step();
    checks++;
    if (instruction !== 3'd0) begin
      errors++; $display("FAIL reset_instruction got %0d want 0", instruction);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (slideshow_on !== 1'b0) begin
      errors++; $display("FAIL reset_slideshow got %b want 0", slideshow_on);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_next();
    logic [2:0] exp_i;
    logic       exp_b;
    btn_next = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      exp_i = (k == 8 || k == 9) ? 3'd2 : 3'd0;
      exp_b = (k >= 8 && k <= 26);
      checks++;
      if (instruction !== exp_i) begin
        errors++; $display("FAIL next_instr edge %0d got %0d want %0d", k, instruction, exp_i);
      end
      checks++;
      if (busy !== exp_b) begin
        errors++; $display("FAIL next_busy edge %0d got %b want %b", k, busy, exp_b);
      end
      if (k == 12) btn_next = 1'b0;
    end
  endtask

  task automatic test_bounce();
    btn_rotate = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      checks++;
      if (instruction !== 3'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bounce edge %0d got instr %0d busy %b want 0 0", k, instruction, busy);
      end
      btn_rotate = (k < 20) && ((k / 2) % 2 == 0);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_i;
    logic       exp_b;
    btn_prev = 1'b1;
    btn_negative = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step();
      exp_i = (k == 8 || k == 9) ? 3'd1 : (k == 28 || k == 29) ? 3'd4 : 3'd0;
      exp_b = (k >= 8 && k <= 26) || (k >= 28 && k <= 30);
      checks++;
      if (instruction !== exp_i) begin
        errors++; $display("FAIL simul_instr edge %0d got %0d want %0d", k, instruction, exp_i);
      end
      checks++;
      if (busy !== exp_b) begin
        errors++; $display("FAIL simul_busy edge %0d got %b want %b", k, busy, exp_b);
      end
      if (k == 12) begin
        btn_prev = 1'b0;
        btn_negative = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_i;
    logic       exp_b;
    btn_rotate = 1'b1;
    btn_negative = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      exp_i = (k == 8 || k == 9) ? 3'd3 : (k == 12 || k == 13) ? 3'd4 : 3'd0;
      exp_b = (k >= 8 && k <= 10) || (k >= 12 && k <= 14);
      checks++;
      if (instruction !== exp_i) begin
        errors++; $display("FAIL b2b_instr edge %0d got %0d want %0d", k, instruction, exp_i);
      end
      checks++;
      if (busy !== exp_b) begin
        errors++; $display("FAIL b2b_busy edge %0d got %b want %b", k, busy, exp_b);
      end
      if (k == 8) begin
        btn_rotate = 1'b0;
        btn_negative = 1'b0;
      end
    end
  endtask

  // Three accepted rotate presses land at edges 9, 17 and 25, all while busy.
  task automatic test_press_during_wait();
    logic [2:0] exp_i;
    logic       exp_b;
    btn_next = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      exp_i = (k == 8 || k == 9) ? 3'd2 : (k == 28 || k == 29) ? 3'd3 : 3'd0;
      exp_b = (k >= 8 && k <= 26) || (k >= 28 && k <= 30);
      checks++;
      if (instruction !== exp_i) begin
        errors++; $display("FAIL wait_instr edge %0d got %0d want %0d", k, instruction, exp_i);
      end
      checks++;
      if (busy !== exp_b) begin
        errors++; $display("FAIL wait_busy edge %0d got %b want %b", k, busy, exp_b);
      end
      if (k == 12) btn_next = 1'b0;
      btn_rotate = (k >= 3 && k < 7) || (k >= 11 && k < 15) || (k >= 19 && k < 23);
    end
  endtask

  task automatic test_reset_mid_issue();
    btn_next = 1'b1;
    for (int k = 1; k <= 8; k++) step();
    checks++;
    if (instruction !== 3'd2) begin
      errors++; $display("FAIL rstmid_pre got %0d want 2", instruction);
    end
    rst = 1'b1;
    btn_next = 1'b0;
    step();
    checks++;
    if (instruction !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_post got instr %0d busy %b want 0 0", instruction, busy);
    end
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      checks++;
      if (instruction !== 3'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet edge %0d got instr %0d busy %b want 0 0", k, instruction, busy);
      end
    end
  endtask

`ifdef F2_SLIDESHOW_EN
  task automatic test_slideshow();
    logic [2:0] exp_i;
    logic       exp_s;
    btn_slide = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      step();
      exp_i = (k == 40 || k == 41 || k == 92 || k == 93) ? 3'd2 : 3'd0;
      exp_s = (k >= 7 && k < 107);
      checks++;
      if (instruction !== exp_i) begin
        errors++; $display("FAIL slide_instr edge %0d got %0d want %0d", k, instruction, exp_i);
      end
      checks++;
      if (slideshow_on !== exp_s) begin
        errors++; $display("FAIL slide_on edge %0d got %b want %b", k, slideshow_on, exp_s);
      end
      if (k == 6 || k == 106) btn_slide = 1'b0;
      if (k == 100) btn_slide = 1'b1;
    end
  endtask
`else
  task automatic test_slideshow_off();
    btn_slide = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      checks++;
      if (slideshow_on !== 1'b0 || instruction !== 3'd0) begin
        errors++;
        $display("FAIL slide_off edge %0d got on %b instr %0d want 0 0", k, slideshow_on, instruction);
      end
      if (k == 8) btn_slide = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_next();
    test_bounce();
    test_simultaneous();
    test_back_to_back();
    test_press_during_wait();
    test_reset_mid_issue();
`ifdef F2_SLIDESHOW_EN
    test_slideshow();
`else
    test_slideshow_off();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
